rr_mux8_arbiter: RTL and testbench

- Round-robin arbiter that shares one 8:1 single-bit mux datapath between 8 requesters.
- Drives the mux's 3-bit select as the encoded grant, so select bit 0 → s0, bit 1 → s1, bit 2 → s2; requester k uses mux data input ik.
- Grants are registered and one-hot, with a bounded hold time.
- Sits between the requesting sources and the mux instance, so that only the owner's data reaches y.

---
 rtl/rr_mux8_arbiter_pkg.sv | 12 +
 rtl/rr_mux8_arbiter_if.sv | 13 +
 rtl/rr_mux8_arbiter_pick.sv | 27 ++
 rtl/rr_mux8_arbiter.sv | 113 +++++++++++
 tb/tb_rr_mux8_arbiter.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/rr_mux8_arbiter_pkg.sv
// Shared constants and state encoding for the 8-way round-robin mux arbiter.
package rr_mux8_arbiter_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned SEL_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/rr_mux8_arbiter_if.sv
// Request/grant bundle between the requesting sources and the arbiter.
interface rr_mux8_arbiter_if;
    import rr_mux8_arbiter_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [SEL_W-1:0] sel;
    logic             valid;
    logic             owner_done;

    modport master (output req, input gnt, sel, valid, owner_done);
    modport slave  (input req, output gnt, sel, valid, owner_done);
endinterface

// File: rtl/rr_mux8_arbiter_pick.sv
// Combinational round-robin pick: first unmasked request at or after start, with wrap.
module rr_pick8
    import rr_mux8_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] start,
    input  logic [N_REQ-1:0] mask,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = start + SEL_W'(i);
            if (!found && req[cand] && !mask[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/rr_mux8_arbiter.sv
// Round-robin arbiter driving an 8:1 mux select with registered one-hot grants
// and a bounded hold time per owner.
module rr_mux8_arbiter
    import rr_mux8_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 4,
    parameter int unsigned CNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    rr_mux8_arbiter_if.slave   bus
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_e           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             valid_q, valid_d;
    logic             owner_done_q, owner_done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] last_q, last_d;

    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;

    // Masking the current owner only matters on timeout; on a drop its req is already 0.
    rr_pick8 u_pick (
        .req   (bus.req),
        .start (last_q + SEL_W'(1)),
        .mask  (gnt_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        sel_d        = sel_q;
        valid_d      = valid_q;
        cnt_d        = cnt_q;
        last_d       = last_q;
        owner_done_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = BUSY;
                    gnt_d   = N_REQ'(1) << pick_idx;
                    sel_d   = pick_idx;
                    valid_d = 1'b1;
                    last_d  = pick_idx;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (bus.req[sel_q]) begin
                    if (cnt_q < HOLD_LAST) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else if (pick_found) begin
                        gnt_d        = N_REQ'(1) << pick_idx;
                        sel_d        = pick_idx;
                        last_d       = pick_idx;
                        cnt_d        = '0;
                        owner_done_d = 1'b1;
                    end else begin
                        cnt_d = '0;
                    end
                end else begin
                    owner_done_d = 1'b1;
                    cnt_d        = '0;
                    if (pick_found) begin
                        gnt_d  = N_REQ'(1) << pick_idx;
                        sel_d  = pick_idx;
                        last_d = pick_idx;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        sel_d   = '0;
                        valid_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            gnt_q        <= '0;
            sel_q        <= '0;
            valid_q      <= 1'b0;
            owner_done_q <= 1'b0;
            cnt_q        <= '0;
            last_q       <= SEL_W'(N_REQ - 1);
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            sel_q        <= sel_d;
            valid_q      <= valid_d;
            owner_done_q <= owner_done_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.sel        = sel_q;
    assign bus.valid      = valid_q;
    assign bus.owner_done = owner_done_q;

endmodule

// File: tb/tb_rr_mux8_arbiter.sv
// Directed and random-stress bench for rr_mux8_arbiter with MAX_HOLD=4.
module tb_rr_mux8_arbiter;

    localparam int unsigned MAX_HOLD = 4;
    localparam int unsigned BOUND    = 7 * MAX_HOLD + 1;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    rr_mux8_arbiter_if bus ();

    rr_mux8_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle past it before sampling or driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        bus.req = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        bus.req = 8'hFF;
        step();
        vectors++;
        if (bus.gnt !== 8'h00 || bus.sel !== 3'd0 || bus.valid !== 1'b0 || bus.owner_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: gnt=%h sel=%0d valid=%b od=%b, required gnt=00 sel=0 valid=0 od=0",
                     bus.gnt, bus.sel, bus.valid, bus.owner_done);
        end
        rst_n = 1'b1;
        step();
        vectors++;
        if (bus.gnt !== 8'h01 || bus.sel !== 3'd0 || bus.valid !== 1'b1) begin
            miscompares++;
            $display("FAIL first_grant: gnt=%h sel=%0d valid=%b, required gnt=01 sel=0 valid=1",
                     bus.gnt, bus.sel, bus.valid);
        end
    endtask

    task automatic test_alternate();
        logic [7:0] exp_gnt;
        logic [2:0] exp_sel;
        logic       exp_od;
        do_reset();
        bus.req = 8'h24;
        for (int k = 0; k < 16; k++) begin
            step();
            exp_gnt = ((k / 4) % 2 == 1) ? 8'h20 : 8'h04;
            exp_sel = ((k / 4) % 2 == 1) ? 3'd5 : 3'd2;
            exp_od  = (k != 0) && (k % 4 == 0);
            vectors++;
            if (bus.gnt !== exp_gnt || bus.sel !== exp_sel || bus.owner_done !== exp_od || bus.valid !== 1'b1) begin
                miscompares++;
                $display("FAIL alternate[%0d]: gnt=%h sel=%0d od=%b valid=%b, required gnt=%h sel=%0d od=%b valid=1",
                         k, bus.gnt, bus.sel, bus.owner_done, bus.valid, exp_gnt, exp_sel, exp_od);
            end
        end
    endtask

    task automatic test_single_hold();
        do_reset();
        bus.req = 8'h08;
        for (int k = 0; k < 10; k++) begin
            step();
            vectors++;
            if (bus.gnt !== 8'h08 || bus.sel !== 3'd3 || bus.owner_done !== 1'b0) begin
                miscompares++;
                $display("FAIL single_hold[%0d]: gnt=%h sel=%0d od=%b, required gnt=08 sel=3 od=0",
                         k, bus.gnt, bus.sel, bus.owner_done);
            end
        end
        bus.req = 8'h00;
        step();
        vectors++;
        if (bus.gnt !== 8'h00 || bus.valid !== 1'b0 || bus.owner_done !== 1'b1) begin
            miscompares++;
            $display("FAIL single_drop: gnt=%h valid=%b od=%b, required gnt=00 valid=0 od=1",
                     bus.gnt, bus.valid, bus.owner_done);
        end
        step();
        vectors++;
        if (bus.owner_done !== 1'b0 || bus.valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_drop_after: od=%b valid=%b, required od=0 valid=0", bus.owner_done, bus.valid);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.req = 8'h40;
        step();
        vectors++;
        if (bus.gnt !== 8'h40) begin
            miscompares++;
            $display("FAIL b2b_owner6: gnt=%h, required 40", bus.gnt);
        end
        bus.req = 8'h81;
        step();
        vectors++;
        if (bus.gnt !== 8'h80 || bus.sel !== 3'd7 || bus.valid !== 1'b1 || bus.owner_done !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_to7: gnt=%h sel=%0d valid=%b od=%b, required gnt=80 sel=7 valid=1 od=1",
                     bus.gnt, bus.sel, bus.valid, bus.owner_done);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            vectors++;
            if (bus.gnt !== 8'h80 || bus.owner_done !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b_hold7[%0d]: gnt=%h od=%b, required gnt=80 od=0", k, bus.gnt, bus.owner_done);
            end
        end
        step();
        vectors++;
        if (bus.gnt !== 8'h01 || bus.sel !== 3'd0 || bus.valid !== 1'b1 || bus.owner_done !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_to0: gnt=%h sel=%0d valid=%b od=%b, required gnt=01 sel=0 valid=1 od=1",
                     bus.gnt, bus.sel, bus.valid, bus.owner_done);
        end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        bus.req = 8'h10;
        step();
        step();
        vectors++;
        if (bus.gnt !== 8'h10 || bus.sel !== 3'd4) begin
            miscompares++;
            $display("FAIL midrst_owner4: gnt=%h sel=%0d, required gnt=10 sel=4", bus.gnt, bus.sel);
        end
        rst_n = 1'b0;
        step();
        vectors++;
        if (bus.gnt !== 8'h00 || bus.sel !== 3'd0 || bus.valid !== 1'b0 || bus.owner_done !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_abort: gnt=%h sel=%0d valid=%b od=%b, required gnt=00 sel=0 valid=0 od=0",
                     bus.gnt, bus.sel, bus.valid, bus.owner_done);
        end
        rst_n   = 1'b1;
        bus.req = 8'h11;
        step();
        vectors++;
        if (bus.gnt !== 8'h01 || bus.sel !== 3'd0) begin
            miscompares++;
            $display("FAIL midrst_prio0: gnt=%h sel=%0d, required gnt=01 sel=0", bus.gnt, bus.sel);
        end
        step();
        step();
        step();
        step();
        vectors++;
        if (bus.gnt !== 8'h10 || bus.sel !== 3'd4 || bus.owner_done !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_then4: gnt=%h sel=%0d od=%b, required gnt=10 sel=4 od=1",
                     bus.gnt, bus.sel, bus.owner_done);
        end
    endtask

    task automatic test_random();
        int         wait_cnt [8];
        logic [7:0] req_v;
        logic       bad;
        do_reset();
        req_v = '0;
        for (int i = 0; i < 8; i++) wait_cnt[i] = 0;
        for (int c = 0; c < 10000; c++) begin
            for (int b = 0; b < 8; b++)
                if ($urandom_range(0, 7) == 0) req_v[b] = ~req_v[b];
            bus.req = req_v;
            step();
            bad = 1'b0;
            if ((bus.gnt & (bus.gnt - 8'd1)) != 8'h00) bad = 1'b1;
            if (bus.valid !== (bus.gnt != 8'h00)) bad = 1'b1;
            if (bus.valid && bus.gnt !== (8'h01 << bus.sel)) bad = 1'b1;
            for (int b = 0; b < 8; b++) begin
                if (req_v[b] && !bus.gnt[b]) wait_cnt[b]++;
                else wait_cnt[b] = 0;
                if (wait_cnt[b] > BOUND) bad = 1'b1;
            end
            vectors++;
            if (bad) begin
                miscompares++;
                if (miscompares < 20)
                    $display("FAIL random[%0d]: req=%h gnt=%h sel=%0d valid=%b, required one-hot gnt matching sel/valid and waits <= %0d",
                             c, req_v, bus.gnt, bus.sel, bus.valid, BOUND);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        bus.req     = '0;
        #1;
        test_reset();
        test_alternate();
        test_single_hold();
        test_back_to_back();
        test_reset_mid_grant();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
